// File: rtl/mem_access_unit_if.sv
// Data-memory bus bundle between the memory access sequencer and the bus.
// One valid/ready request channel plus a single-cycle response pulse.
interface mem_access_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wmask;
  logic                  bus_resp_valid;
  logic [DATA_W-1:0]     bus_resp_data;

  modport master (
    output bus_req_valid,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_wmask,
    input  bus_req_ready,
    input  bus_resp_valid,
    input  bus_resp_data
  );

  modport slave (
    input  bus_req_valid,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_wmask,
    output bus_req_ready,
    output bus_resp_valid,
    output bus_resp_data
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access sequencer: one load/store at a time onto a valid/ready
// bus, stalling the pipeline until the response and draining aborted ones.
module mem_access_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_re,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  input  logic                abort,
  output logic                mem_stall,
  output logic [DATA_W-1:0]   mem_rdata,
  mem_access_unit_if.master   bus
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t              r_state;
  logic                r_valid;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_req;

  assign w_req     = mem_re | mem_we;
  assign mem_stall = w_req & ~abort & (r_state != S_DONE);
  assign mem_rdata = r_rdata;

  assign bus.bus_req_valid = r_valid;
  assign bus.bus_we        = r_we;
  assign bus.bus_addr      = r_addr;
  assign bus.bus_wdata     = r_wdata;
  assign bus.bus_wmask     = r_wmask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req && !abort) begin
            r_we    <= mem_we;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_wmask <= mem_wmask;
            r_valid <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // an accepted request always owes a response, even if aborted
          if (bus.bus_req_ready) begin
            r_valid <= 1'b0;
            r_state <= abort ? S_DRAIN : S_WAIT;
          end else if (abort) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.bus_resp_valid && !abort) begin
            if (!r_we) r_rdata <= bus.bus_resp_data;
            r_state <= S_DONE;
          end else if (bus.bus_resp_valid) begin
            r_state <= S_IDLE;
          end else if (abort) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.bus_resp_valid) r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed abort/reset scenarios plus random
// transactions checked against a cycle-timeline reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_re;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        abort;
  logic        mem_stall;
  logic [63:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_rdata = '0;

  mem_access_unit_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .abort     (abort),
    .mem_stall (mem_stall),
    .mem_rdata (mem_rdata),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_idle();
    mem_re = 0; mem_we = 0; abort = 0;
    mem_addr = rnd64(); mem_wdata = rnd64();
    mem_wmask = 8'($urandom);
    bus.bus_req_ready = 0;
    bus.bus_resp_valid = 0;
    bus.bus_resp_data = rnd64();
  endtask

  task automatic drive_req(input bit is_rd, input logic [63:0] a,
                           input logic [63:0] wd, input logic [7:0] wm);
    mem_re = is_rd; mem_we = !is_rd;
    mem_addr = a; mem_wdata = wd; mem_wmask = wm;
  endtask

  // Complete access: ready held low for rdl cycles, response lat cycles
  // after acceptance; stall ends in the DONE cycle.
  task automatic run_txn(input bit is_rd, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] wm,
                         input int rdl, input int lat,
                         input logic [63:0] rsp, input string nm);
    int acc, rc, dn;
    acc = 1 + rdl;
    rc  = acc + lat;
    dn  = rc + 1;
    for (int k = 0; k <= dn; k++) begin
      @(posedge clk); #1;
      drive_idle();
      drive_req(is_rd, a, wd, wm);
      bus.bus_req_ready  = (k == acc);
      bus.bus_resp_valid = (k == rc);
      if (k == rc) bus.bus_resp_data = rsp;
      @(negedge clk);
      if (k == dn && is_rd) exp_rdata = rsp;
      n_cmp++;
      if (mem_stall !== (k < dn)) begin
        n_bad++;
        $display("FAIL %s stall k=%0d got %b want %b", nm, k,
                 mem_stall, (k < dn));
      end
      n_cmp++;
      if (bus.bus_req_valid !== (k >= 1 && k <= acc)) begin
        n_bad++;
        $display("FAIL %s valid k=%0d got %b", nm, k, bus.bus_req_valid);
      end
      if (k >= 1 && k <= acc) begin
        n_cmp++;
        if (bus.bus_addr !== a || bus.bus_we !== !is_rd ||
            bus.bus_wdata !== wd || bus.bus_wmask !== wm) begin
          n_bad++;
          $display("FAIL %s busout k=%0d got a=%h we=%b d=%h m=%h want a=%h we=%b d=%h m=%h",
                   nm, k, bus.bus_addr, bus.bus_we, bus.bus_wdata,
                   bus.bus_wmask, a, !is_rd, wd, wm);
        end
      end
      n_cmp++;
      if (mem_rdata !== exp_rdata) begin
        n_bad++;
        $display("FAIL %s rdata k=%0d got %h want %h", nm, k,
                 mem_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.bus_req_valid !== 0 || bus.bus_we !== 0 || bus.bus_addr !== 0 ||
        bus.bus_wdata !== 0 || bus.bus_wmask !== 0 || mem_rdata !== 0 ||
        mem_stall !== 0) begin
      n_bad++;
      $display("FAIL reset_outs got v=%b we=%b a=%h d=%h m=%h rd=%h st=%b want all 0",
               bus.bus_req_valid, bus.bus_we, bus.bus_addr, bus.bus_wdata,
               bus.bus_wmask, mem_rdata, mem_stall);
    end
    mem_re = 1;
    #1;
    n_cmp++;
    if (mem_stall !== 1) begin
      n_bad++;
      $display("FAIL reset_stall got %b want 1", mem_stall);
    end
    @(posedge clk); #1;
    rst = 0;
    drive_idle();
    exp_rdata = '0;
  endtask

  task automatic test_read_basic();
    run_txn(1, 64'h1000, rnd64(), 8'hff, 0, 1,
            64'hDEAD_BEEF_0000_1234, "read_min");
  endtask

  task automatic test_store_stall();
    run_txn(0, 64'h8000_0010, 64'h55, 8'h01, 3, 1, rnd64(), "store_rdy");
  endtask

  task automatic test_drain();
    logic [63:0] a2;
    a2 = rnd64();
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      drive_idle();
      if (k < 3) drive_req(1, 64'h2000, 0, 8'hff);
      else drive_req(1, a2, 0, 8'hff);
      bus.bus_req_ready  = (k == 1);
      abort              = (k == 2);
      bus.bus_resp_valid = (k == 4);
      @(negedge clk);
      n_cmp++;
      if (mem_stall !== (k != 2)) begin
        n_bad++;
        $display("FAIL drain_stall k=%0d got %b want %b", k, mem_stall, k != 2);
      end
      n_cmp++;
      if (bus.bus_req_valid !== (k == 1)) begin
        n_bad++;
        $display("FAIL drain_valid k=%0d got %b want %b", k,
                 bus.bus_req_valid, k == 1);
      end
      n_cmp++;
      if (mem_rdata !== exp_rdata) begin
        n_bad++;
        $display("FAIL drain_rdata k=%0d got %h want %h", k, mem_rdata, exp_rdata);
      end
    end
    run_txn(1, a2, 0, 8'hff, 0, 1, rnd64(), "drain_next");
  endtask

  task automatic test_abort_resp();
    for (int k = 0; k <= 2; k++) begin
      @(posedge clk); #1;
      drive_idle();
      drive_req(1, 64'h3000, 0, 8'hff);
      bus.bus_req_ready  = (k == 1);
      bus.bus_resp_valid = (k == 2);
      abort              = (k == 2);
      @(negedge clk);
      n_cmp++;
      if (mem_stall !== (k != 2)) begin
        n_bad++;
        $display("FAIL abresp_stall k=%0d got %b want %b", k, mem_stall, k != 2);
      end
    end
    run_txn(1, 64'h3008, 0, 8'hff, 1, 2, rnd64(), "abresp_next");
  endtask

  task automatic test_abort_req();
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      drive_idle();
      if (k <= 2) drive_req(1, 64'h4000, 0, 8'hff);
      abort = (k == 2);
      @(negedge clk);
      n_cmp++;
      if (mem_stall !== (k < 2)) begin
        n_bad++;
        $display("FAIL abreq_stall k=%0d got %b want %b", k, mem_stall, k < 2);
      end
      n_cmp++;
      if (bus.bus_req_valid !== (k == 1 || k == 2)) begin
        n_bad++;
        $display("FAIL abreq_valid k=%0d got %b", k, bus.bus_req_valid);
      end
    end
    run_txn(0, 64'h4010, rnd64(), 8'h0f, 0, 1, rnd64(), "abreq_next");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); #1;
      drive_idle();
      if (k <= 2) drive_req(1, 64'h5000, 0, 8'hff);
      bus.bus_req_ready = (k == 1);
      rst = (k == 2);
    end
    exp_rdata = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.bus_req_valid !== 0 || bus.bus_we !== 0 || bus.bus_addr !== 0 ||
        bus.bus_wdata !== 0 || bus.bus_wmask !== 0 || mem_rdata !== 0 ||
        mem_stall !== 0) begin
      n_bad++;
      $display("FAIL rstmid_outs got v=%b a=%h rd=%h st=%b want 0",
               bus.bus_req_valid, bus.bus_addr, mem_rdata, mem_stall);
    end
    run_txn(1, 64'h5008, 0, 8'hff, 0, 1, rnd64(), "rstmid_next");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (mem_stall !== 0 || bus.bus_req_valid !== 0) begin
          n_bad++;
          $display("FAIL rnd_idle t=%0d got st=%b v=%b want 0 0", t,
                   mem_stall, bus.bus_req_valid);
        end
      end
      run_txn($urandom_range(0, 1) == 1, rnd64(), rnd64(), 8'($urandom),
              $urandom_range(0, 3), $urandom_range(1, 3), rnd64(), "rnd");
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1, 64'h6000, 0, 8'hff, 0, 1, rnd64(), "b2b_0");
    run_txn(0, 64'h6008, rnd64(), 8'hf0, 0, 1, rnd64(), "b2b_1");
    run_txn(1, 64'h6010, 0, 8'hff, 2, 1, rnd64(), "b2b_2");
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_store_stall();
    test_drain();
    test_abort_resp();
    test_abort_req();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
